poll_booth_multi: RTL and testbench

- Parametrised N-candidate voting counter with a session state machine, ballot edge detection, invalid-ballot rejection and saturating tallies.
- Sits between debounced voter buttons and the results display / reporting logic.
- Tallies are hidden while voting is open and published only after the session closes.

---
 rtl/poll_booth_multi_pkg.sv | 28 ++
 rtl/poll_booth_multi_if.sv | 28 ++
 rtl/poll_booth_multi_winner_scan.sv | 85 ++++++++
 rtl/poll_booth_multi.sv | 87 ++++++++
 tb/tb_poll_booth_multi.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/poll_booth_multi_pkg.sv
// Shared types for the voting counter: session/scan state encodings and a one-hot test.
package poll_pkg;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_OPEN   = 2'd1;
    localparam logic [1:0] ENC_CLOSED = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_OPEN   = ENC_OPEN,
        ST_CLOSED = ENC_CLOSED
    } state_t;

    typedef enum logic {
        SC_SCAN = 1'b0,
        SC_DONE = 1'b1
    } scan_t;

    function automatic logic is_onehot(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return (cnt == 5'd1);
    endfunction

endpackage

// File: rtl/poll_booth_multi_if.sv
// Button/control and result bus of the voting counter; master drives i_*, slave drives o_*.
interface poll_booth_multi_if #(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 16
);
    logic                      i_open;
    logic                      i_close;
    logic [N_CAND-1:0]         i_vote;
    logic [1:0]                o_state;
    logic [N_CAND*CNT_W-1:0]   o_counts;
    logic [CNT_W-1:0]          o_invalid;
    logic                      o_results_valid;
    logic [3:0]                o_winner;
    logic                      o_tie;
    logic                      o_winner_valid;

    modport master (
        output i_open, i_close, i_vote,
        input  o_state, o_counts, o_invalid, o_results_valid,
               o_winner, o_tie, o_winner_valid
    );

    modport slave (
        input  i_open, i_close, i_vote,
        output o_state, o_counts, o_invalid, o_results_valid,
               o_winner, o_tie, o_winner_valid
    );
endinterface

// File: rtl/poll_booth_multi_winner_scan.sv
// Sequential winner scanner: one tally per cycle, lowest index wins, tie flag on repeated maximum.
module poll_winner_scan
    import poll_pkg::*;
#(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_active,
    input  logic [N_CAND*CNT_W-1:0] i_tallies,
    output logic [3:0]              o_winner,
    output logic                    o_tie,
    output logic                    o_valid
);

    scan_t            r_st,   w_st_n;
    logic [3:0]       r_idx,  w_idx_n;
    logic [CNT_W-1:0] r_best, w_best_n;
    logic [3:0]       r_win,  w_win_n;
    logic             r_tie,  w_tie_n;
    logic [CNT_W-1:0] w_cur;

    assign w_cur = i_tallies[r_idx*CNT_W +: CNT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st   <= SC_SCAN;
            r_idx  <= '0;
            r_best <= '0;
            r_win  <= '0;
            r_tie  <= 1'b0;
        end else begin
            r_st   <= w_st_n;
            r_idx  <= w_idx_n;
            r_best <= w_best_n;
            r_win  <= w_win_n;
            r_tie  <= w_tie_n;
        end
    end

    // Scanner state is held cleared whenever the session is not CLOSED.
    always_comb begin
        w_st_n   = r_st;
        w_idx_n  = r_idx;
        w_best_n = r_best;
        w_win_n  = r_win;
        w_tie_n  = r_tie;
        if (!i_active) begin
            w_st_n   = SC_SCAN;
            w_idx_n  = '0;
            w_best_n = '0;
            w_win_n  = '0;
            w_tie_n  = 1'b0;
        end else begin
            unique case (r_st)
                SC_SCAN: begin
                    if (r_idx == 4'd0) begin
                        w_best_n = w_cur;
                        w_win_n  = 4'd0;
                        w_tie_n  = 1'b0;
                    end else if (w_cur > r_best) begin
                        w_best_n = w_cur;
                        w_win_n  = r_idx;
                        w_tie_n  = 1'b0;
                    end else if (w_cur == r_best) begin
                        w_tie_n  = 1'b1;
                    end
                    w_idx_n = r_idx + 4'd1;
                    if (r_idx == 4'(N_CAND - 1)) begin
                        w_st_n = SC_DONE;
                    end
                end
                SC_DONE: begin
                end
                default: w_st_n = SC_SCAN;
            endcase
        end
    end

    assign o_valid  = i_active && (r_st == SC_DONE);
    assign o_winner = o_valid ? r_win : 4'd0;
    assign o_tie    = o_valid && r_tie;

endmodule

// File: rtl/poll_booth_multi.sv
// N-candidate voting counter with session FSM and saturating tallies.
// Optional winner scan built when POLL_WINNER_EN is defined.
module poll_booth_multi
    import poll_pkg::*;
#(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    poll_booth_multi_if.slave  bus
);

    state_t                        r_state, w_next;
    logic [N_CAND-1:0]             r_vote_q;
    logic [N_CAND-1:0][CNT_W-1:0]  r_tally;
    logic [CNT_W-1:0]              r_invalid;
    logic                          w_event;
    logic                          w_onehot;
    logic                          w_clear;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (bus.i_open)  w_next = ST_OPEN;
            ST_OPEN:   if (bus.i_close) w_next = ST_CLOSED;
            ST_CLOSED: if (bus.i_open)  w_next = ST_OPEN;
            default:   w_next = ST_IDLE;
        endcase
    end

    // A ballot needs the buttons to have been all-released on the previous cycle.
    assign w_clear  = (r_state != ST_OPEN) && (w_next == ST_OPEN);
    assign w_event  = (r_state == ST_OPEN) && (r_vote_q == '0) && (bus.i_vote != '0);
    assign w_onehot = is_onehot(16'(bus.i_vote));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vote_q  <= '0;
            r_tally   <= '0;
            r_invalid <= '0;
        end else begin
            r_state  <= w_next;
            r_vote_q <= bus.i_vote;
            if (w_clear) begin
                r_tally   <= '0;
                r_invalid <= '0;
            end else if (w_event) begin
                if (w_onehot) begin
                    for (int unsigned k = 0; k < N_CAND; k++) begin
                        if (bus.i_vote[k] && (r_tally[k] != '1)) begin
                            r_tally[k] <= r_tally[k] + CNT_W'(1);
                        end
                    end
                end else if (r_invalid != '1) begin
                    r_invalid <= r_invalid + CNT_W'(1);
                end
            end
        end
    end

    assign bus.o_state         = r_state;
    assign bus.o_counts        = (r_state == ST_CLOSED) ? r_tally : '0;
    assign bus.o_invalid       = r_invalid;
    assign bus.o_results_valid = (r_state == ST_CLOSED);

`ifdef POLL_WINNER_EN
    poll_winner_scan #(
        .N_CAND (N_CAND),
        .CNT_W  (CNT_W)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .i_active  (r_state == ST_CLOSED),
        .i_tallies (r_tally),
        .o_winner  (bus.o_winner),
        .o_tie     (bus.o_tie),
        .o_valid   (bus.o_winner_valid)
    );
`else
    assign bus.o_winner       = 4'd0;
    assign bus.o_tie          = 1'b0;
    assign bus.o_winner_valid = 1'b0;
`endif

endmodule

// File: tb/tb_poll_booth_multi.sv
// Bench for poll_booth_multi: a 16-bit and a 3-bit tally instance driven in lockstep,
// compared every cycle against an arithmetic session model.
module tb_poll_booth_multi;

    localparam int NC = 4;
    localparam int WA = 16;
    localparam int WB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poll_booth_multi_if #(.N_CAND(NC), .CNT_W(WA)) ifA ();
    poll_booth_multi_if #(.N_CAND(NC), .CNT_W(WB)) ifB ();

    poll_booth_multi #(.N_CAND(NC), .CNT_W(WA)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    poll_booth_multi #(.N_CAND(NC), .CNT_W(WB)) dutB (.clk(clk), .rst(rst), .bus(ifB));

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: session 0 idle / 1 open / 2 closed, unbounded counts.
    int          m_st;
    int          m_tal [NC];
    int          m_inv;
    logic [3:0]  m_prev;
    int          m_cyc;

    task automatic model_reset();
        m_st = 0; m_inv = 0; m_prev = 4'd0; m_cyc = 0;
        for (int k = 0; k < NC; k++) m_tal[k] = 0;
    endtask

    task automatic model_step(input logic op, input logic cl, input logic [3:0] v);
        int old;
        old = m_st;
        if (m_st == 1 && m_prev == 4'd0 && v != 4'd0) begin
            if ($countones(v) == 1) begin
                for (int k = 0; k < NC; k++) if (v[k]) m_tal[k]++;
            end else begin
                m_inv++;
            end
        end
        if ((m_st == 0 || m_st == 2) && op) begin
            m_st = 1; m_inv = 0;
            for (int k = 0; k < NC; k++) m_tal[k] = 0;
        end else if (m_st == 1 && cl) begin
            m_st = 2; m_cyc = 0;
        end
        if (old == 2 && m_st == 2) m_cyc++;
        m_prev = v;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string p, input int w,
                             input logic [1:0] st, input logic [63:0] cnt,
                             input logic [63:0] inv, input logic rv,
                             input logic [3:0] win, input logic tie, input logic wv);
        int          cap, c, best, bi, nbest;
        logic [63:0] ec;
        logic [3:0]  e_win;
        logic        e_tie, e_wv;
        cap = (1 << w) - 1;
        ec = 64'd0; best = -1; bi = 0; nbest = 0;
        for (int k = 0; k < NC; k++) begin
            c = (m_tal[k] > cap) ? cap : m_tal[k];
            if (m_st == 2) ec = ec | (64'(c) << (k * w));
            if (c > best) begin best = c; bi = k; nbest = 1; end
            else if (c == best) nbest++;
        end
        e_wv = 1'b0; e_win = 4'd0; e_tie = 1'b0;
`ifdef POLL_WINNER_EN
        if (m_st == 2 && m_cyc >= NC) begin
            e_wv = 1'b1; e_win = 4'(bi); e_tie = (nbest > 1);
        end
`endif
        chk({p, "_state"},   64'(st),  64'(m_st));
        chk({p, "_counts"},  cnt,      ec);
        chk({p, "_invalid"}, inv,      64'((m_inv > cap) ? cap : m_inv));
        chk({p, "_rvalid"},  64'(rv),  64'(m_st == 2));
        chk({p, "_winner"},  64'(win), 64'(e_win));
        chk({p, "_tie"},     64'(tie), 64'(e_tie));
        chk({p, "_wvalid"},  64'(wv),  64'(e_wv));
    endtask

    task automatic check_all();
        check_dut("A", WA, ifA.o_state, 64'(ifA.o_counts), 64'(ifA.o_invalid),
                  ifA.o_results_valid, ifA.o_winner, ifA.o_tie, ifA.o_winner_valid);
        check_dut("B", WB, ifB.o_state, 64'(ifB.o_counts), 64'(ifB.o_invalid),
                  ifB.o_results_valid, ifB.o_winner, ifB.o_tie, ifB.o_winner_valid);
    endtask

    task automatic cycle(input logic op, input logic cl, input logic [3:0] v);
        ifA.i_open = op; ifA.i_close = cl; ifA.i_vote = v;
        ifB.i_open = op; ifB.i_close = cl; ifB.i_vote = v;
        @(posedge clk);
        model_step(op, cl, v);
        #1;
        check_all();
    endtask

    task automatic press(input logic [3:0] v);
        cycle(1'b0, 1'b0, v);
        cycle(1'b0, 1'b0, 4'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        logic [3:0] rv;
        int         r;
        ifA.i_open = 0; ifA.i_close = 0; ifA.i_vote = '0;
        ifB.i_open = 0; ifB.i_close = 0; ifB.i_vote = '0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Basic tally 0,1,1,3
        cycle(1'b1, 1'b0, 4'd0);
        press(4'b0001); press(4'b0010); press(4'b0010); press(4'b1000);
        chk("hidden_in_open", 64'(ifA.o_counts), 64'd0);
        cycle(1'b0, 1'b1, 4'd0);
        chk("basic_counts", 64'(ifA.o_counts), {16'd1, 16'd0, 16'd2, 16'd1});
        idle(5);

        // New session from CLOSED; invalid ballot, held press, vote on close edge
        cycle(1'b1, 1'b0, 4'd0);
        chk("reopen_cleared_inv", 64'(ifA.o_invalid), 64'd0);
        press(4'b0110);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'b0001);
        cycle(1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 4'b0100);
        chk("inv_count", 64'(ifA.o_invalid), 64'd1);
        chk("held_once", 64'(ifA.o_counts[15:0]), 64'd1);
        chk("close_edge_vote", 64'(ifA.o_counts[47:32]), 64'd1);
        cycle(1'b0, 1'b0, 4'd0);

        // open+close together while OPEN closes the session
        cycle(1'b1, 1'b0, 4'd0);
        press(4'b1000);
        cycle(1'b1, 1'b1, 4'd0);
        chk("open_close_both", 64'(ifA.o_state), 64'd2);

        // Tallies {3,5,5,1}
        cycle(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) press(4'b0001);
        for (int i = 0; i < 5; i++) press(4'b0010);
        for (int i = 0; i < 5; i++) press(4'b0100);
        press(4'b1000);
        cycle(1'b0, 1'b1, 4'd0);
        idle(NC);
`ifdef POLL_WINNER_EN
        chk("win_3551", 64'(ifA.o_winner), 64'd1);
        chk("tie_3551", 64'(ifA.o_tie), 64'd1);
        chk("wv_3551", 64'(ifA.o_winner_valid), 64'd1);
`endif

        // Empty session, then saturation on cand2
        cycle(1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 4'd0);
        idle(NC + 1);
        cycle(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 9; i++) press(4'b0100);
        cycle(1'b0, 1'b1, 4'd0);
        chk("sat_b_cand2", 64'(ifB.o_counts[8:6]), 64'd7);
        chk("nosat_a_cand2", 64'(ifA.o_counts[47:32]), 64'd9);
        idle(NC);

        // Button held across the IDLE->OPEN edge
        rst = 1'b1; #1; model_reset(); check_all();
        @(negedge clk); rst = 1'b0;
        cycle(1'b0, 1'b0, 4'b0001);
        cycle(1'b1, 1'b0, 4'b0001);
        cycle(1'b0, 1'b0, 4'b0001);
        cycle(1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 4'd0);
        chk("held_across_open", 64'(ifA.o_counts[15:0]), 64'd0);

        // Randomised sessions
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: rv = 4'd0;
                5, 6, 7:       rv = 4'd1 << $urandom_range(0, 3);
                default:       rv = 4'($urandom);
            endcase
            cycle(r < 6, r >= 6 && r < 10, rv);
        end

        // Async reset in the middle of an open session
        cycle(1'b1, 1'b0, 4'd0);
        press(4'b0010); press(4'b1100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_mid_invalid", 64'(ifA.o_invalid), 64'd0);
        @(negedge clk); rst = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
